// File: rtl/snell_pkg.sv
// Shared types for the snell_law front-end sequencer:
// FSM state encoding and the order of the datapath load phases.
package snell_pkg;

    localparam int DATA_W_DEF = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_N2,
        LOAD_T1,
        LOAD_T2,
        CALC,
        RESULT
    } state_t;

    // Entry phase for a full load, entry phase when n2 is reused
    localparam state_t FIRST_LOAD = LOAD_N2;
    localparam state_t SKIP_LOAD  = LOAD_T1;

    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = CALC;
        unique case (s)
            LOAD_N2: n = LOAD_T1;
            LOAD_T1: n = LOAD_T2;
            LOAD_T2: n = CALC;
            default: n = CALC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/snell_law_sequencer.sv
// Front-end controller that loads operands into the snell_law datapath
// through one-hot strobes, then captures and presents its result.
module snell_law_sequencer
    import snell_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HOLD_CYCLES = 1,
    parameter int RESULT_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_n2,
    input  logic [DATA_W-1:0] in_t1,
    input  logic [DATA_W-1:0] in_t2,
    input  logic              in_skip_n2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              dp_n2_sel,
    output logic              dp_t1_sel,
    output logic              dp_t2_sel,
    output logic              dp_out_sel,
    output logic [DATA_W-1:0] dp_input,
    input  logic [DATA_W-1:0] dp_output
);

    localparam int MAX_HL = (HOLD_CYCLES > RESULT_LAT) ? HOLD_CYCLES : RESULT_LAT;
    localparam int CNT_W  = $clog2(MAX_HL) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(RESULT_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_n2;
    logic [DATA_W-1:0] r_t1;
    logic [DATA_W-1:0] r_t2;
    logic              r_n2_sel;
    logic              r_t1_sel;
    logic              r_t2_sel;
    logic              r_out_sel;
    logic [DATA_W-1:0] r_dp_input;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;

    state_t            w_next;
    logic              w_accept;
    logic              w_done;
    logic [DATA_W-1:0] w_n2;
    logic [DATA_W-1:0] w_t1;
    logic [DATA_W-1:0] w_t2;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_done   = (r_cnt == ((r_state == CALC) ? CALC_LAST : HOLD_LAST));

    // On the accept edge the operands are not yet latched; bypass them
    assign w_n2 = (r_state == IDLE) ? in_n2 : r_n2;
    assign w_t1 = (r_state == IDLE) ? in_t1 : r_t1;
    assign w_t2 = (r_state == IDLE) ? in_t2 : r_t2;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = in_skip_n2 ? SKIP_LOAD : FIRST_LOAD;
            end
            LOAD_N2, LOAD_T1, LOAD_T2: begin
                if (w_done) w_next = next_phase(r_state);
            end
            CALC: begin
                if (w_done) w_next = RESULT;
            end
            RESULT: begin
                if (r_res_valid && res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_n2        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_n2_sel    <= 1'b0;
            r_t1_sel    <= 1'b0;
            r_t2_sel    <= 1'b0;
            r_out_sel   <= 1'b0;
            r_dp_input  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

            if (w_accept) begin
                r_n2 <= in_n2;
                r_t1 <= in_t1;
                r_t2 <= in_t2;
            end

            // Outputs are decoded from the next state so they are registered
            r_n2_sel    <= (w_next == LOAD_N2);
            r_t1_sel    <= (w_next == LOAD_T1);
            r_t2_sel    <= (w_next == LOAD_T2);
            r_out_sel   <= (w_next == CALC);
            r_res_valid <= (w_next == RESULT);

            unique case (w_next)
                LOAD_N2: r_dp_input <= w_n2;
                LOAD_T1: r_dp_input <= w_t1;
                LOAD_T2: r_dp_input <= w_t2;
                default: r_dp_input <= '0;
            endcase

            if ((r_state == CALC) && (w_next == RESULT)) r_res_data <= dp_output;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign dp_n2_sel  = r_n2_sel;
    assign dp_t1_sel  = r_t1_sel;
    assign dp_t2_sel  = r_t2_sel;
    assign dp_out_sel = r_out_sel;
    assign dp_input   = r_dp_input;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;

endmodule
